ex_mem_stage: RTL

- Execute stage plus EX/MEM pipeline register; consumes every field the ID/EX register produces (operands, sign-extended immediate, Rs/Rt/Rd, ALUOp and control bits).
- Resolves data hazards by forwarding, decodes ALU control, computes the ALU result and write-register index, then registers results and MEM/WB control for the memory stage.
- Sits between the ID/EX register and data memory. Load-use stalls are handled upstream as a zeroed ID/EX bubble, so this block never stalls.

---
 rtl/ex_pkg.sv | 54 +++++
 rtl/ex_alu.sv | 43 ++++
 rtl/ex_mem_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU/forwarding encodings for the execute stage
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_NONE
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    // Unknown funct codes map to ALU_NONE so they produce a zero result.
    function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_NOR: op = ALU_NOR;
                    FUNCT_SLT: op = ALU_SLT;
                    default:   op = ALU_NONE;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU with zero and signed-overflow flags
module ex_alu
    import ex_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] op_a_i,
    input  logic [DW-1:0] op_b_i,
    input  alu_op_e       op_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o,
    output logic          ovf_o
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;

    assign sum  = op_a_i + op_b_i;
    assign diff = op_a_i - op_b_i;

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum;
                ovf_o    = (op_a_i[DW-1] == op_b_i[DW-1]) && (sum[DW-1] != op_a_i[DW-1]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (op_a_i[DW-1] != op_b_i[DW-1]) && (diff[DW-1] != op_a_i[DW-1]);
            end
            ALU_AND: result_o = op_a_i & op_b_i;
            ALU_OR:  result_o = op_a_i | op_b_i;
            ALU_NOR: result_o = ~(op_a_i | op_b_i);
            ALU_SLT: result_o = {{(DW-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with forwarding and EX/MEM register
// Optional overflow trap (EX_MEM_Ovf output) is enabled by defining EX_OVF_TRAP_EN.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ID_EX_RsData,
    input  logic [DW-1:0] ID_EX_RtData,
    input  logic [DW-1:0] ID_EX_SignExtImm,
    input  logic [RW-1:0] ID_EX_Rs,
    input  logic [RW-1:0] ID_EX_Rt,
    input  logic [RW-1:0] ID_EX_Rd,
    input  logic [1:0]    ID_EX_ALUOp,
    input  logic          ID_EX_RegWrite,
    input  logic          ID_EX_MemWrite,
    input  logic          ID_EX_MemRead,
    input  logic          ID_EX_ALUSrc,
    input  logic          ID_EX_MemtoReg,
    input  logic          ID_EX_RegDst,
    input  logic          MEM_WB_RegWrite,
    input  logic [RW-1:0] MEM_WB_WriteReg,
    input  logic [DW-1:0] WB_Data,
    input  logic          Flush,
    output logic [DW-1:0] EX_MEM_ALUResult,
    output logic [DW-1:0] EX_MEM_WriteData,
    output logic [RW-1:0] EX_MEM_WriteReg,
    output logic          EX_MEM_RegWrite,
    output logic          EX_MEM_MemWrite,
    output logic          EX_MEM_MemRead,
    output logic          EX_MEM_MemtoReg,
`ifdef EX_OVF_TRAP_EN
    output logic          EX_MEM_Ovf,
`endif
    output logic          EX_MEM_Zero
);

    // EX/MEM always outranks MEM/WB; r0 is never a forwarding source.
    function automatic fwd_sel_e fwd_select(
        input logic [RW-1:0] src,
        input logic          exm_rw,
        input logic [RW-1:0] exm_wr,
        input logic          wb_rw,
        input logic [RW-1:0] wb_wr
    );
        if (exm_rw && (exm_wr != '0) && (exm_wr == src))
            return FWD_MEM;
        else if (wb_rw && (wb_wr != '0) && (wb_wr == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    logic [DW-1:0] alu_result_q, write_data_q;
    logic [RW-1:0] write_reg_q;
    logic          reg_write_q, mem_write_q, mem_read_q, mem_to_reg_q, zero_q;

    logic [DW-1:0] alu_result_d, write_data_d;
    logic [RW-1:0] write_reg_d;
    logic          reg_write_d, mem_write_d, mem_read_d, mem_to_reg_d, zero_d;

    fwd_sel_e      fwd_a_sel, fwd_b_sel;
    logic [DW-1:0] fwd_a, fwd_b, op_b;
    alu_op_e       alu_op;
    logic          alu_ovf;

    always_comb begin
        fwd_a_sel = fwd_select(ID_EX_Rs, reg_write_q, write_reg_q, MEM_WB_RegWrite, MEM_WB_WriteReg);
        fwd_b_sel = fwd_select(ID_EX_Rt, reg_write_q, write_reg_q, MEM_WB_RegWrite, MEM_WB_WriteReg);
    end

    always_comb begin
        fwd_a = ID_EX_RsData;
        case (fwd_a_sel)
            FWD_MEM: fwd_a = alu_result_q;
            FWD_WB:  fwd_a = WB_Data;
            default: fwd_a = ID_EX_RsData;
        endcase
    end

    always_comb begin
        fwd_b = ID_EX_RtData;
        case (fwd_b_sel)
            FWD_MEM: fwd_b = alu_result_q;
            FWD_WB:  fwd_b = WB_Data;
            default: fwd_b = ID_EX_RtData;
        endcase
    end

    assign op_b   = ID_EX_ALUSrc ? ID_EX_SignExtImm : fwd_b;
    assign alu_op = alu_decode(ID_EX_ALUOp, ID_EX_SignExtImm[5:0]);

    ex_alu #(.DW(DW)) u_alu (
        .op_a_i   (fwd_a),
        .op_b_i   (op_b),
        .op_i     (alu_op),
        .result_o (alu_result_d),
        .zero_o   (zero_d),
        .ovf_o    (alu_ovf)
    );

    assign write_data_d = fwd_b;
    assign write_reg_d  = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rt;

`ifdef EX_OVF_TRAP_EN
    logic ovf_d, ovf_q;
    assign ovf_d = alu_ovf && (ID_EX_ALUOp == ALUOP_FUNCT);
`else
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
`endif

    always_comb begin
        reg_write_d  = ID_EX_RegWrite && !Flush;
        mem_write_d  = ID_EX_MemWrite && !Flush;
        mem_read_d   = ID_EX_MemRead  && !Flush;
        mem_to_reg_d = ID_EX_MemtoReg && !Flush;
`ifdef EX_OVF_TRAP_EN
        if (ovf_d) begin
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            zero_q       <= zero_d;
        end
    end

`ifdef EX_OVF_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end
    assign EX_MEM_Ovf = ovf_q;
`endif

    assign EX_MEM_ALUResult = alu_result_q;
    assign EX_MEM_WriteData = write_data_q;
    assign EX_MEM_WriteReg  = write_reg_q;
    assign EX_MEM_RegWrite  = reg_write_q;
    assign EX_MEM_MemWrite  = mem_write_q;
    assign EX_MEM_MemRead   = mem_read_q;
    assign EX_MEM_MemtoReg  = mem_to_reg_q;
    assign EX_MEM_Zero      = zero_q;

endmodule
